// File: rtl/mul_heap_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_heap_sequencer
// Description : Sequences one unsigned WIDTH x WIDTH multiply through a
//               serial-load partial-product compressor and holds the product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_heap_sequencer #(
    parameter int WIDTH    = 16,
    parameter int COMP_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [2*WIDTH-2:0]   ser_out,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);

    localparam int c_COLS   = 2*WIDTH-1;
    localparam int c_STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_WAIT_W = (COMP_LAT > 1) ? $clog2(COMP_LAT+1) : 1;
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(WIDTH-1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(COMP_LAT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SHIFT   = 3'd1;
    localparam logic [2:0] c_WAIT    = 3'd2;
    localparam logic [2:0] c_CAPTURE = 3'd3;
    localparam logic [2:0] c_HOLD    = 3'd4;

    logic [2:0]             r_state;
    logic [c_STEP_W-1:0]    r_step;
    logic [c_WAIT_W-1:0]    r_wait;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_prod;
    logic                   r_out_valid;

    logic [c_COLS-1:0][WIDTH-1:0] w_heap;
    logic [c_STEP_W-1:0]          w_k;

    // Bits are fed MSB-first so bit k of each column lands at register position k.
    assign w_k = c_LAST_STEP - r_step;

    generate
        for (genvar c = 0; c < c_COLS; c++) begin : g_col
            localparam int c_H   = (c+1 < c_COLS-c) ? c+1 : c_COLS-c;
            localparam int c_JLO = (c-WIDTH+1 > 0) ? c-WIDTH+1 : 0;
            for (genvar k = 0; k < WIDTH; k++) begin : g_bit
                if (k < c_H) begin : g_pp
                    assign w_heap[c][k] = r_a[c_JLO+k] & r_b[c-c_JLO-k];
                end else begin : g_zero
                    assign w_heap[c][k] = 1'b0;
                end
            end
            assign ser_out[c] = (r_state == c_SHIFT) & w_heap[c][w_k];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_step      <= '0;
            r_wait      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_step  <= '0;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (r_step == c_LAST_STEP) begin
                        if (COMP_LAT == 0) begin
                            r_state <= c_CAPTURE;
                        end else begin
                            r_wait  <= c_WAIT_LOAD;
                            r_state <= c_WAIT;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                c_WAIT: begin
                    if (r_wait <= c_WAIT_ONE) begin
                        r_state <= c_CAPTURE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                // The heap result is only meaningful on this one cycle.
                c_CAPTURE: begin
                    r_prod      <= prod_in;
                    r_out_valid <= 1'b1;
                    r_state     <= c_HOLD;
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign out_valid = r_out_valid;
    assign out_prod  = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_mul_heap_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_heap_sequencer
// Description : Directed bench for mul_heap_sequencer with a column-shift
//               compressor model (combinational and 2-stage pipelined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_heap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [15:0] in_a = '0, in_b = '0;
    logic [30:0] ser_out;
    logic [31:0] prod_in, out_prod;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, busy2;
    logic [15:0] in_a2 = '0, in_b2 = '0;
    logic [30:0] ser_out2;
    logic [31:0] prod_in2, out_prod2;

    logic [30:0][15:0] cols0 = '0;
    logic [30:0][15:0] cols2 = '0;
    logic [31:0]       p1 = '0, p2 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_heap_sequencer #(.WIDTH(16), .COMP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .ser_out(ser_out), .prod_in(prod_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .busy(busy)
    );

    mul_heap_sequencer #(.WIDTH(16), .COMP_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .ser_out(ser_out2), .prod_in(prod_in2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_prod(out_prod2), .busy(busy2)
    );

    // Compressor model: weight each column's ones by 2^c.
    function automatic logic [31:0] heap_sum(input logic [30:0][15:0] cols);
        logic [31:0] s;
        s = '0;
        for (int c = 0; c < 31; c++)
            for (int k = 0; k < 16; k++)
                s = s + (32'(cols[c][k]) << c);
        return s;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 31; c++) begin
            cols0[c] <= {cols0[c][14:0], ser_out[c]};
            cols2[c] <= {cols2[c][14:0], ser_out2[c]};
        end
        p1 <= heap_sum(cols2);
        p2 <= p1;
    end

    assign prod_in  = heap_sum(cols0);
    assign prod_in2 = p2;

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_prod !== 32'h0) begin errors++; $display("FAIL reset_out_prod: got %h expected 00000000", out_prod); end
        checks++; if (ser_out !== 31'h0) begin errors++; $display("FAIL reset_ser_out: got %h expected 0", ser_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        bit rdy_bad;
        @(negedge clk); in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0; rdy_bad = (in_ready !== 1'b0);
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
        end
        checks++; if (n != 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", n); end
        checks++; if (out_prod !== 32'h0000000F) begin errors++; $display("FAIL basic_prod: got %h expected 0000000f", out_prod); end
        checks++; if (rdy_bad) begin errors++; $display("FAIL basic_in_ready_low: got 1 expected 0"); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_all_ones();
        bit col15_bad, col0_bad;
        int n;
        @(negedge clk); in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        col15_bad = 1'b0; col0_bad = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (s > 0) begin @(posedge clk); #1; end
            if (ser_out[15] !== 1'b1) col15_bad = 1'b1;
            if (ser_out[0] !== (s == 15)) col0_bad = 1'b1;
        end
        checks++; if (col15_bad) begin errors++; $display("FAIL ones_col15: got a zero step expected 1 on all steps"); end
        checks++; if (col0_bad) begin errors++; $display("FAIL ones_col0: got wrong pattern expected 1 only on step 15"); end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (out_prod !== 32'hFFFE0001) begin errors++; $display("FAIL ones_prod: got %h expected fffe0001", out_prod); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk); in_a = 16'h8000; in_b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (out_prod !== 32'h00008000) begin errors++; $display("FAIL hold_prod: got %h expected 00008000", out_prod); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); in_valid = (i % 2 == 0); in_a = 16'hFFFF; in_b = 16'hFFFF;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 32'h00008000 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_stable[%0d]: got valid=%b prod=%h ready=%b expected 1/00008000/0", i, out_valid, out_prod, in_ready);
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_exit: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_ghost_job: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit stale;
        @(negedge clk); in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ser_out === 31'h0) begin errors++; $display("FAIL mid_ser_active: got %h expected nonzero", ser_out); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_prod !== 32'h0 || ser_out !== 31'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_async_reset: got valid=%b prod=%h ser=%h busy=%b ready=%b expected 0/0/0/0/1",
                               out_valid, out_prod, ser_out, busy, in_ready);
        end
        @(negedge clk) rst = 1'b0;
        stale = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1; end
        checks++; if (stale) begin errors++; $display("FAIL mid_discard: got activity expected none after reset"); end
        @(negedge clk); in_a = 16'd2; in_b = 16'd2; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n != 17 || out_prod !== 32'h00000004) begin errors++; $display("FAIL mid_next_job: got lat=%0d prod=%h expected 17/00000004", n, out_prod); end
        @(posedge clk); #1;
    endtask

    task automatic test_comp_lat2();
        int n;
        @(negedge clk); in_a2 = 16'h1234; in_b2 = 16'h5678; in_valid2 = 1'b1;
        @(posedge clk); #1 in_valid2 = 1'b0;
        n = 0;
        while (out_valid2 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n != 19) begin errors++; $display("FAIL lat2_latency: got %0d expected 19", n); end
        checks++; if (out_prod2 !== 32'h06260060) begin errors++; $display("FAIL lat2_prod: got %h expected 06260060", out_prod2); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] prods [2];
        int rise [2];
        int np, exit1, acc2;
        prods[0] = '0; prods[1] = '0; rise[0] = -1; rise[1] = -1;
        np = 0; exit1 = -1; acc2 = -1;
        @(negedge clk); in_a = 16'd7; in_b = 16'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_a = 16'hABCD; in_b = 16'h0010;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && np < 2) begin prods[np] = out_prod; rise[np] = e; np++; end
            if (np == 1 && exit1 < 0 && out_valid === 1'b0 && busy === 1'b0) exit1 = e;
            if (exit1 >= 0 && acc2 < 0 && busy === 1'b1) begin acc2 = e; in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        checks++; if (rise[0] != 17 || prods[0] !== 32'h0000003F) begin errors++; $display("FAIL b2b_first: got edge=%0d prod=%h expected 17/0000003f", rise[0], prods[0]); end
        checks++; if (exit1 != 18) begin errors++; $display("FAIL b2b_hold_exit: got edge %0d expected 18", exit1); end
        checks++; if (acc2 != 19) begin errors++; $display("FAIL b2b_second_accept: got edge %0d expected 19", acc2); end
        checks++; if (rise[1] != 36 || prods[1] !== 32'h000ABCD0) begin errors++; $display("FAIL b2b_second: got edge=%0d prod=%h expected 36/000abcd0", rise[1], prods[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_hold();
        test_reset_mid();
        test_comp_lat2();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_heap_sequencer.md
Name: mul_heap_sequencer

Overview:
- Controller that sequences the serial-load partial-product compressor harness for one unsigned WIDTH x WIDTH multiply at a time.
- Accepts an operand pair on a valid/ready handshake.
- Serially drives the per-column shift inputs (one line per column, column heights 1..WIDTH..1) over WIDTH cycles, waits out the compressor latency, then captures the 2*WIDTH-bit product.
- Presents the product on a valid/ready output.

Parameters:
- WIDTH, 16: operand width; drives 2*WIDTH-1 columns.
- COMP_LAT, 0: compressor latency in cycles from heap present to product valid (0 = combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- ser_out  out  2*WIDTH-1  bit c drives column c serial input (srcc_).
- prod_in  in  2*WIDTH  compressor result, bit c = dstc.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_prod  out  2*WIDTH  captured product.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; step/wait counters = 0; operand registers = 0.
  - out_prod = 0; out_valid = 0; ser_out = 0; busy = 0; in_ready = 1.
  - Reset mid-operation discards the job; no product is ever emitted for it.
- States: IDLE, SHIFT, WAIT, CAPTURE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid at edge E0: register in_a/in_b, step s = 0, go to SHIFT.
- SHIFT: WIDTH cycles, s = 0..WIDTH-1.
  - Column c has height h_c = min(c+1, 2*WIDTH-1-c) and j_lo = max(0, c-WIDTH+1).
  - During step s, with k = WIDTH-1-s: ser_out[c] = a[j_lo+k] & b[c-j_lo-k] if k < h_c, else 0.
  - Registered-column bit k therefore holds a[j_lo+k]&b[c-j_lo-k] after the final shift edge E_WIDTH.
  - ser_out is driven from registered state only (no combinational path from in_a/in_b).
  - After step WIDTH-1: if COMP_LAT = 0 go to CAPTURE, else go to WAIT with counter = COMP_LAT.
- WAIT:
  - ser_out = 0 (the harness keeps shifting; zeros flush the columns harmlessly).
  - Decrement the counter each cycle; when it reaches 1, go to CAPTURE.
- CAPTURE:
  - One cycle, sampled at edge E_(WIDTH+COMP_LAT+1).
  - out_prod <= prod_in, out_valid <= 1, go to HOLD.
  - The heap is valid only in this single cycle; capture timing is exact.
- HOLD:
  - out_valid = 1; out_prod stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - out_valid never drops without out_ready.
- Latency: acceptance edge to out_valid = WIDTH + COMP_LAT + 1 edges (17 for defaults).
- Throughput: one job per WIDTH + COMP_LAT + 3 cycles minimum.
- in_ready = 0 in every state except IDLE; in_valid outside IDLE is ignored and the operands are not consumed.
- Simultaneous events:
  - in_valid held high in HOLD while out_ready arrives: the new job is accepted on the next cycle (from IDLE), not the same one.
  - out_ready high on the cycle out_valid first rises: transfer completes at the next edge.
- Width rule: the product is unsigned, 2*WIDTH bits, with no truncation. Column 2*WIDTH-1 has no serial input; only the carry comes from prod_in.

Test Plan:
- 3 x 5, COMP_LAT=0, out_ready=1 -> out_valid rises 17 edges after accept; out_prod = 0x0000000F; in_ready low throughout.
- 0xFFFF x 0xFFFF -> out_prod = 0xFFFE0001. Check ser_out[15] = 1 on all 16 steps and ser_out[0] = 1 only on step 15.
- 0x8000 x 0x0001 with out_ready low for 5 cycles after out_valid -> out_valid and out_prod = 0x00008000 held stable; in_valid pulses during HOLD are ignored; return to IDLE after the out_ready edge.
- rst asserted at step 7 of SHIFT -> all outputs zero immediately (asynchronous). A following job 2 x 2 yields 0x00000004 with no stale output.
- COMP_LAT=2 with a 2-stage pipelined compressor model, 0x1234 x 0x5678 -> out_prod = 0x06260060, out_valid at edge 19.
- Back-to-back jobs 7x9 then 0xABCD x 0x0010 with continuous in_valid/out_ready -> products 0x0000003F and 0x000ABCD0 in order; second acceptance exactly 1 cycle after the first HOLD exit.
